// File: rtl/uio_nibble_tx.sv
// Transmit end of the 4-bit nibble link: byte FIFO feeding a two-phase strobe/ack nibble sender.
// Define UIO_NIBBLE_TX_PARITY_EN to drive even parity of the current nibble on uio_out[6].
module uio_nibble_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP_HI,
        STROBE_HI,
        WAIT_HI,
        SETUP_LO,
        STROBE_LO,
        WAIT_LO,
        ABORT
    } state_t;

    state_t                 state;
    logic [7:0]             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic [OCC_W-1:0]       occ_next;
    logic [7:0]             sr;
    logic [3:0]             nibble;
    logic                   strobe;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   push;
    logic                   pop;
    logic                   empty;
    logic                   unused_uio_in;

    assign unused_uio_in = ^{uio_in[7:6], uio_in[4:0]};

    assign empty = (occ == '0);
    assign push  = in_valid & in_ready;
    assign pop   = (state == IDLE) & ~empty & ena;
    assign busy  = (state != IDLE) | ~empty;
    assign ack_s = ack_sync[SYNC_STAGES-1];

`ifdef UIO_NIBBLE_TX_PARITY_EN
    function automatic logic even_parity(input logic [3:0] n);
        return ^n;
    endfunction

    assign uio_out = {1'b0, even_parity(nibble), 1'b0, strobe, nibble};
    assign uio_oe  = 8'h5F;
`else
    assign uio_out = {3'b000, strobe, nibble};
    assign uio_oe  = 8'h1F;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], uio_in[5]};
        end
    end

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 1'b1;
        end else if (!push && pop) begin
            occ_next = occ - 1'b1;
        end
    end

    // FIFO control; pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ      <= occ_next;
            in_ready <= (occ_next != OCC_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
        if (pop) begin
            sr <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            strobe      <= 1'b0;
            nibble      <= 4'h0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= SETUP_HI;
                    end
                end
                SETUP_HI: begin
                    nibble <= sr[7:4];
                    state  <= STROBE_HI;
                end
                SETUP_LO: begin
                    nibble <= sr[3:0];
                    state  <= STROBE_LO;
                end
                STROBE_HI, STROBE_LO: begin
                    strobe  <= ~strobe;
                    tmo_cnt <= '0;
                    state   <= (state == STROBE_HI) ? WAIT_HI : WAIT_LO;
                end
                // The flag is raised on entry to ABORT, so a coincident err_clr loses
                WAIT_HI, WAIT_LO: begin
                    if (ack_s == strobe) begin
                        state <= (state == WAIT_HI) ? SETUP_LO : IDLE;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                        state       <= ABORT;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ABORT: begin
                    strobe <= ack_s;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uio_nibble_tx.sv
// Bench for uio_nibble_tx: far-end ack echo, nibble scoreboard, directed and random traffic.
module tb_uio_nibble_tx;
    localparam int FIFO_DEPTH = 4;
`ifdef UIO_NIBBLE_TX_PARITY_EN
    localparam bit         PAR    = 1'b1;
    localparam logic [7:0] OE_EXP = 8'h5F;
`else
    localparam bit         PAR    = 1'b0;
    localparam logic [7:0] OE_EXP = 8'h1F;
`endif

    logic       clk = 1'b0;
    logic       rst, ena, in_valid, err_clr;
    logic [7:0] in_data;
    logic       in_ready, busy, err_timeout;
    logic [7:0] uio_in, uio_out, uio_oe;

    logic       ack_drv, d1, d2, echo_en, stall_en, mon_en;
    logic [7:0] uio_noise;
    logic [3:0] sb [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;

    assign uio_in = {uio_noise[7:6], ack_drv, uio_noise[4:0]};

    uio_nibble_tx #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(255), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic exp_par(input logic [3:0] n);
        return PAR ? ^n : 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Far end: ack follows strobe two cycles later, optionally with random extra stalls
    initial begin
        ack_drv = 1'b0; d1 = 1'b0; d2 = 1'b0;
        forever begin
            @(negedge clk);
            if (echo_en && !(stall_en && $urandom_range(3) == 0)) ack_drv = d2;
            d2 = d1;
            d1 = uio_out[4];
        end
    end

    // Scoreboard: every strobe toggle must present the next expected nibble
    initial begin
        logic       prev_strobe, cur_strobe;
        logic [3:0] prev_nib, cur_nib, exp_nib;
        prev_strobe = 1'b0;
        prev_nib    = 4'h0;
        forever begin
            @(negedge clk);
            cur_strobe = uio_out[4];
            cur_nib    = uio_out[3:0];
            check("uio_oe", uio_oe, OE_EXP);
            check("reserved_bits", {uio_out[7], uio_out[5]}, 2'b00);
            check("parity_bit", uio_out[6], exp_par(cur_nib));
            if (mon_en) begin
                if (cur_strobe != prev_strobe) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_strobe");
                    end else begin
                        exp_nib = sb.pop_front();
                        check("nibble", cur_nib, exp_nib);
                        check("nibble_setup", prev_nib, cur_nib);
                    end
                end
                if (sb.size() != 0) check("busy_model", busy, 1'b1);
                if ((sb.size() + 1) / 2 < FIFO_DEPTH) check("in_ready_model", in_ready, 1'b1);
            end
            prev_strobe = cur_strobe;
            prev_nib    = cur_nib;
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit track, output bit acc);
        in_data  = b;
        in_valid = 1'b1;
        acc      = in_ready;
        @(posedge clk);
        if (acc && track) begin
            sb.push_back(b[7:4]);
            sb.push_back(b[3:0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_toggle(input string name, input int max_cyc, output bit ok);
        logic s0;
        s0 = uio_out[4];
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (uio_out[4] != s0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
        check({name, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        bit acc, ok;
        int t0;
        logic [7:0] lit;
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00; err_clr = 1'b0;
        echo_en = 1'b1; stall_en = 1'b0; mon_en = 1'b0; uio_noise = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_err", err_timeout, 1'b0);
        mon_en = 1'b1;

        // Single byte 0xA5: pop at N+1, high nibble at N+2, strobe toggle at N+3
        push_byte(8'hA5, 1'b1, acc);
        check("a5_accept", acc, 1'b1);
        check("a5_busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("a5_setup_hi", uio_out, 8'h0A);
        @(negedge clk);
        check("a5_strobe_hi", uio_out, 8'h1A);
        wait_toggle("a5_lo_toggle", 40, ok);
        check("a5_strobe_lo", uio_out, 8'h05);
        wait_idle("a5", 40);

        // Back-pressure: acks held off while five bytes are offered back to back
        echo_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i), 1'b1, acc);
            check("bp_accept", acc, 1'b1);
        end
        check("bp_full", in_ready, 1'b0);
        push_byte(8'h06, 1'b1, acc);
        check("bp_refuse", acc, 1'b0);
        repeat (15) @(negedge clk);
        check("bp_still_full", in_ready, 1'b0);
        echo_en = 1'b1;
        wait_idle("bp", 600);

        // Timeout: no ack ever arrives for 0xE1
        mon_en  = 1'b0;
        echo_en = 1'b0;
        push_byte(8'hE1, 1'b0, acc);
        wait_toggle("tmo_hi_toggle", 10, ok);
        t0 = cyc;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("tmo_flag");
        check("tmo_latency", cyc - t0, 256);
        @(negedge clk);
        check("tmo_strobe_resync", uio_out[4], ack_drv);
        check("tmo_busy", busy, 1'b0);
        echo_en = 1'b1;
        mon_en  = 1'b1;
        push_byte(8'h3C, 1'b1, acc);
        wait_idle("after_tmo", 60);
        check("err_sticky", err_timeout, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", err_timeout, 1'b0);

        // Reset during WAIT_LO with two bytes still queued
        mon_en = 1'b0;
        push_byte(8'h11, 1'b0, acc);
        push_byte(8'h22, 1'b0, acc);
        push_byte(8'h33, 1'b0, acc);
        wait_toggle("rst_hi_toggle", 10, ok);
        wait_toggle("rst_lo_toggle", 40, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        sb.delete();
        repeat (10) @(negedge clk);
        mon_en = 1'b1;
        push_byte(8'h7E, 1'b1, acc);
        wait_idle("after_rst", 60);

        // Parity literals: 0x96 -> 0,0 and 0x17 -> 1,1 (bit forced low without the feature)
        push_byte(8'h96, 1'b1, acc);
        wait_toggle("par96_hi", 10, ok);
        check("par96_hi", {uio_out[6], uio_out[3:0]}, {1'b0, 4'h9});
        wait_toggle("par96_lo", 40, ok);
        check("par96_lo", {uio_out[6], uio_out[3:0]}, {1'b0, 4'h6});
        wait_idle("par96", 40);
        lit = 8'h17;
        push_byte(lit, 1'b1, acc);
        wait_toggle("par17_hi", 10, ok);
        check("par17_hi", {uio_out[6], uio_out[3:0]}, {PAR, 4'h1});
        wait_toggle("par17_lo", 40, ok);
        check("par17_lo", {uio_out[6], uio_out[3:0]}, {PAR, 4'h7});
        wait_idle("par17", 40);

        // Random traffic with ena gaps, ack stalls and noise on unused uio_in bits
        stall_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            ena       = ($urandom_range(9) != 0);
            uio_noise = 8'($urandom);
            if ($urandom_range(2) == 0) begin
                push_byte(8'($urandom), 1'b1, acc);
            end else begin
                @(negedge clk);
            end
        end
        ena       = 1'b1;
        stall_en  = 1'b0;
        uio_noise = 8'h00;
        wait_idle("random", 3000);
        check("random_no_err", err_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
